// File: rtl/conn_setup_sequencer_pkg.sv
// Shared NIC types for the connection-setup path: the frame format and command
// set used by the RPC unit, plus the sequencer state encoding.
package conn_setup_sequencer_pkg;

    typedef enum logic [2:0] {
        setUpNop          = 3'd0,
        setUpConnId       = 3'd1,
        setUpOpen         = 3'd2,
        setUpDestIPv4     = 3'd3,
        setUpDestPort     = 3'd4,
        setUpClientFlowId = 3'd5,
        setUpQPFields     = 3'd6,
        setUpEnable       = 3'd7
    } ConnSetupCmd;

    typedef struct packed {
        ConnSetupCmd  cmd;
        logic [31:0]  data;
        logic [63:0]  big_data;
    } ConnSetupFrame;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_CONN_ID     = 4'd1,
        S_OPEN        = 4'd2,
        S_DEST_IP     = 4'd3,
        S_DEST_PORT   = 4'd4,
        S_FLOW_ID     = 4'd5,
        S_QP          = 4'd6,
        S_ENABLE      = 4'd7,
        S_WAIT_STATUS = 4'd8,
        S_RESP        = 4'd9
    } SeqState;

    // big_data layout of the setUpQPFields frame, shared with the RPC parser.
    localparam int QP_NUM_MSB = 63;
    localparam int QP_NUM_LSB = 48;
    localparam int P_KEY_MSB  = 47;
    localparam int P_KEY_LSB  = 32;
    localparam int Q_KEY_MSB  = 31;
    localparam int Q_KEY_LSB  = 0;

    typedef struct packed {
        logic [31:0] conn_id;
        logic        open;
        logic [31:0] dest_ip;
        logic [15:0] dest_port;
        logic [31:0] flow_id;
        logic [15:0] remote_qp_num;
        logic [15:0] p_key;
        logic [31:0] q_key;
    } conn_desc_t;

    function automatic logic [63:0] pack_qp_fields(input logic [15:0] qp_num,
                                                   input logic [15:0] p_key,
                                                   input logic [31:0] q_key);
        logic [63:0] big;
        big = '0;
        big[QP_NUM_MSB:QP_NUM_LSB] = qp_num;
        big[P_KEY_MSB:P_KEY_LSB]   = p_key;
        big[Q_KEY_MSB:Q_KEY_LSB]   = q_key;
        return big;
    endfunction

    function automatic logic is_frame_state(input SeqState st);
        return st inside {S_CONN_ID, S_OPEN, S_DEST_IP, S_DEST_PORT,
                          S_FLOW_ID, S_QP, S_ENABLE};
    endfunction

    // Frame carried by each frame state; every other state yields an all-zero frame.
    function automatic ConnSetupFrame build_frame(input SeqState st, input conn_desc_t d);
        ConnSetupFrame f;
        f = '0;
        case (st)
            S_CONN_ID: begin
                f.cmd  = setUpConnId;
                f.data = d.conn_id;
            end
            S_OPEN: begin
                f.cmd  = setUpOpen;
                f.data = {31'd0, d.open};
            end
            S_DEST_IP: begin
                f.cmd  = setUpDestIPv4;
                f.data = d.dest_ip;
            end
            S_DEST_PORT: begin
                f.cmd  = setUpDestPort;
                f.data = {16'd0, d.dest_port};
            end
            S_FLOW_ID: begin
                f.cmd  = setUpClientFlowId;
                f.data = d.flow_id;
            end
            S_QP: begin
                f.cmd      = setUpQPFields;
                f.big_data = pack_qp_fields(d.remote_qp_num, d.p_key, d.q_key);
            end
            S_ENABLE: f.cmd = setUpEnable;
            default:  f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/conn_setup_sequencer.sv
// Connection-setup sequencer: turns one open/close descriptor into the ordered
// ConnSetupFrame sequence, waits for the connection-manager status, and responds.
module conn_setup_sequencer
    import conn_setup_sequencer_pkg::*;
#(
    parameter int NIC_ID         = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FLOW_ID_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [31:0]                      req_conn_id,
    input  logic                             req_open,
    input  logic [31:0]                      req_dest_ip,
    input  logic [15:0]                      req_dest_port,
    input  logic [FLOW_ID_WIDTH-1:0]         req_client_flow_id,
    input  logic [15:0]                      req_remote_qp_num,
    input  logic [15:0]                      req_p_key,
    input  logic [31:0]                      req_q_key,
    output logic                             conn_setup_en_out,
    output logic [$bits(ConnSetupFrame)-1:0] conn_setup_frame_out,
    input  logic                             status_valid_in,
    input  logic                             status_ok_in,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [31:0]                      resp_conn_id,
    output logic                             resp_ok,
    output logic                             resp_timeout,
    output logic                             error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    SeqState       state_q, state_d;
    conn_desc_t    desc_q, desc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    ConnSetupFrame frame_q, frame_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_ok_q, resp_ok_d;
    logic          resp_timeout_q, resp_timeout_d;
    logic          error_q, error_d;

    logic          accept;
    logic          in_wait;
    logic          timeout_hit;

    assign in_wait     = (state_q == S_WAIT_STATUS);
    assign accept      = (state_q == S_IDLE) && req_valid;
    assign timeout_hit = in_wait && !status_valid_in && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        desc_d         = desc_q;
        cnt_d          = cnt_q;
        resp_ok_d      = resp_ok_q;
        resp_timeout_d = resp_timeout_q;
        error_d        = error_q | (status_valid_in && !in_wait);

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    desc_d.conn_id       = req_conn_id;
                    desc_d.open          = req_open;
                    desc_d.dest_ip       = req_dest_ip;
                    desc_d.dest_port     = req_dest_port;
                    desc_d.flow_id       = 32'(req_client_flow_id);
                    desc_d.remote_qp_num = req_remote_qp_num;
                    desc_d.p_key         = req_p_key;
                    desc_d.q_key         = req_q_key;
                    state_d              = S_CONN_ID;
                end
            end
            S_CONN_ID:   state_d = S_OPEN;
            S_OPEN:      state_d = desc_q.open ? S_DEST_IP : S_ENABLE;
            S_DEST_IP:   state_d = S_DEST_PORT;
            S_DEST_PORT: state_d = S_FLOW_ID;
            S_FLOW_ID:   state_d = S_QP;
            S_QP:        state_d = S_ENABLE;
            S_ENABLE: begin
                state_d = S_WAIT_STATUS;
                cnt_d   = '0;
            end
            S_WAIT_STATUS: begin
                // A status arriving on the last counted cycle still beats the timeout.
                if (status_valid_in) begin
                    resp_ok_d      = status_ok_in;
                    resp_timeout_d = 1'b0;
                    state_d        = S_RESP;
                end else if (timeout_hit) begin
                    resp_ok_d      = 1'b0;
                    resp_timeout_d = 1'b1;
                    state_d        = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame outputs are registered from the state being entered, so each frame
        // is visible in exactly the cycle its state is held.
        en_d         = is_frame_state(state_d);
        frame_d      = build_frame(state_d, desc_d);
        resp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the descriptor is a plain register, not a memory, so it is cleared with the rest.
            state_q        <= S_IDLE;
            desc_q         <= '0;
            cnt_q          <= '0;
            en_q           <= 1'b0;
            frame_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_ok_q      <= 1'b0;
            resp_timeout_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            desc_q         <= desc_d;
            cnt_q          <= cnt_d;
            en_q           <= en_d;
            frame_q        <= frame_d;
            resp_valid_q   <= resp_valid_d;
            resp_ok_q      <= resp_ok_d;
            resp_timeout_q <= resp_timeout_d;
            error_q        <= error_d;
        end
    end

    assign req_ready            = (state_q == S_IDLE);
    assign conn_setup_en_out    = en_q;
    assign conn_setup_frame_out = frame_q;
    assign resp_valid           = resp_valid_q;
    assign resp_conn_id         = desc_q.conn_id;
    assign resp_ok              = resp_ok_q;
    assign resp_timeout         = resp_timeout_q;
    assign error                = error_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (timeout_hit) begin
                $info("conn_setup_sequencer[%0d]: status timeout for conn_id 0x%08h",
                      NIC_ID, desc_q.conn_id);
            end
            if (status_valid_in && !in_wait) begin
                $info("conn_setup_sequencer[%0d]: stray status outside WAIT_STATUS (state %0d)",
                      NIC_ID, state_q);
            end
        end
    end
`endif

endmodule
